// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// Latency: none, plain wires.
// Backpressure: the master holds req and its payload until ack, or until it drops the access on timeout.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data-memory req/ack access with timeout, MEM/WB register and forwarding taps; MEM_SUBWORD_EN adds byte/half accesses.
// Latency: non-memory op 1 cycle EX/MEM->MEM/WB; load/store 1 cycle plus the cycles spent waiting for dmem ack.
// Backpressure: mem_stall (combinational) freezes PC, IF/ID and ID/EX while an access waits for ack; abort after TIMEOUT_CYCLES-1 wait cycles.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_ALUout,
    input  logic [31:0] ex_RegB,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic [1:0]  ex_MemSize,
    input  logic        ex_MemSigned,
    input  logic        ex_RegWrite,
    input  logic [4:0]  ex_WriteAddr,
    output logic        mem_stall,
    output logic [31:0] ALUout_EX_MEM_out,
    output logic        RegWrite_EX_MEM,
    output logic [4:0]  WriteAddr_EX_MEM,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_WriteAddr,
    output logic [31:0] ALU_out_MEM_WB_out,
    output logic        mem_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] regb;
        logic        rd;
        logic        wr;
`ifdef MEM_SUBWORD_EN
        logic [1:0]  size;
        logic        sgn;
`endif
        logic        rw;
        logic [4:0]  wa;
    } exmem_t;

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    exmem_t          exmem;
    state_t          state;
    logic [CW-1:0]   cnt;

    logic            memop;
    logic            misaligned;
    logic            bad_align;
    logic            access;
    logic            abort;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     addr;
    logic [31:0]     load_data;

    // A real load or store sits in EX/MEM; a misaligned one never reaches the bus.
    assign memop     = exmem.valid & (exmem.rd | exmem.wr);
    assign bad_align = memop & misaligned;
    assign access    = memop & ~misaligned;
    assign abort     = access & (state == ACCESS) & ~dmem.ack
                     & (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign mem_stall = access & ~dmem.ack & ~abort;

    // Request payload comes straight from EX/MEM, so it stays stable while held.
    assign dmem.req   = access;
    assign dmem.we    = exmem.wr & ~exmem.rd;
    assign dmem.addr  = addr;
    assign dmem.be    = be;
    assign dmem.wdata = wdata;

    assign ALUout_EX_MEM_out = exmem.alu;
    assign RegWrite_EX_MEM   = exmem.valid & exmem.rw;
    assign WriteAddr_EX_MEM  = exmem.wa;

`ifdef MEM_SUBWORD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Lane enables, replicated store data and alignment check from size and low address bits.
    always_comb begin
        be         = 4'hF;
        wdata      = exmem.regb;
        misaligned = 1'b0;
        case (exmem.size)
            2'b00: begin
                be    = 4'b0001 << exmem.alu[1:0];
                wdata = {4{exmem.regb[7:0]}};
            end
            2'b01: begin
                be         = exmem.alu[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{exmem.regb[15:0]}};
                misaligned = exmem.alu[0];
            end
            default: misaligned = (exmem.alu[1:0] != 2'b00);
        endcase
    end

    // Pick the addressed lane of the read data and sign/zero-extend it.
    always_comb begin
        case (exmem.alu[1:0])
            2'd0:    ld_byte = dmem.rdata[7:0];
            2'd1:    ld_byte = dmem.rdata[15:8];
            2'd2:    ld_byte = dmem.rdata[23:16];
            default: ld_byte = dmem.rdata[31:24];
        endcase
        ld_half = exmem.alu[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (exmem.size)
            2'b00:   load_data = {{24{exmem.sgn & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{exmem.sgn & ld_half[15]}}, ld_half};
            default: load_data = dmem.rdata;
        endcase
    end

    assign addr = exmem.alu;
`else
    logic unused_cfg;

    assign be         = 4'hF;
    assign wdata      = exmem.regb;
    assign misaligned = 1'b0;
    assign load_data  = dmem.rdata;
    assign addr       = {exmem.alu[31:2], 2'b00};
    assign unused_cfg = ^{ex_MemSize, ex_MemSigned};
`endif

    // EX/MEM register: accept the EX instruction unless the current access is still waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem <= '0;
        end else if (!mem_stall) begin
            exmem.valid <= ex_valid;
            exmem.alu   <= ex_ALUout;
            exmem.regb  <= ex_RegB;
            exmem.rd    <= ex_MemRead;
            exmem.wr    <= ex_MemWrite;
`ifdef MEM_SUBWORD_EN
            exmem.size  <= ex_MemSize;
            exmem.sgn   <= ex_MemSigned;
`endif
            exmem.rw    <= ex_RegWrite;
            exmem.wa    <= ex_WriteAddr;
        end
    end

    // Access FSM: counts wait cycles after the first unacknowledged request cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !dmem.ack) begin
                        state <= ACCESS;
                        cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (!access || dmem.ack || abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // MEM/WB register: retire on completion, insert a bubble (keeping data) while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid           <= 1'b0;
            wb_RegWrite        <= 1'b0;
            wb_WriteAddr       <= '0;
            ALU_out_MEM_WB_out <= '0;
        end else if (!mem_stall) begin
            wb_valid           <= exmem.valid;
            wb_RegWrite        <= exmem.valid & exmem.rw & ~abort & ~bad_align;
            wb_WriteAddr       <= exmem.wa;
            ALU_out_MEM_WB_out <= (memop & exmem.rd) ? load_data : exmem.alu;
        end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end
    end

    // Sticky error flag: set by a timed-out or misaligned access, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err <= 1'b0;
        end else if (abort || bad_align) begin
            mem_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_ALUout = '0;
    logic [31:0] ex_RegB = '0;
    logic        ex_MemRead = 1'b0;
    logic        ex_MemWrite = 1'b0;
    logic [1:0]  ex_MemSize = 2'b10;
    logic        ex_MemSigned = 1'b0;
    logic        ex_RegWrite = 1'b0;
    logic [4:0]  ex_WriteAddr = '0;
    logic        mem_stall;
    logic [31:0] ALUout_EX_MEM_out;
    logic        RegWrite_EX_MEM;
    logic [4:0]  WriteAddr_EX_MEM;
    logic        wb_valid;
    logic        wb_RegWrite;
    logic [4:0]  wb_WriteAddr;
    logic [31:0] ALU_out_MEM_WB_out;
    logic        mem_err;

    mem_stage_if dmem_bus();

    mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                (clk),
        .reset              (reset),
        .ex_valid           (ex_valid),
        .ex_ALUout          (ex_ALUout),
        .ex_RegB            (ex_RegB),
        .ex_MemRead         (ex_MemRead),
        .ex_MemWrite        (ex_MemWrite),
        .ex_MemSize         (ex_MemSize),
        .ex_MemSigned       (ex_MemSigned),
        .ex_RegWrite        (ex_RegWrite),
        .ex_WriteAddr       (ex_WriteAddr),
        .mem_stall          (mem_stall),
        .ALUout_EX_MEM_out  (ALUout_EX_MEM_out),
        .RegWrite_EX_MEM    (RegWrite_EX_MEM),
        .WriteAddr_EX_MEM   (WriteAddr_EX_MEM),
        .dmem               (dmem_bus),
        .wb_valid           (wb_valid),
        .wb_RegWrite        (wb_RegWrite),
        .wb_WriteAddr       (wb_WriteAddr),
        .ALU_out_MEM_WB_out (ALU_out_MEM_WB_out),
        .mem_err            (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        sgn;
        logic [1:0]  size;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [31:0] regb;
    } ins_t;

    // Expected outcome of one instruction: bus request, retirement and stall count.
    typedef struct {
        bit          has_req;
        int          lat;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          retire;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
        int          stalls;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        req_q[$];
    exp_t        wb_q[$];
    logic [31:0] phys[16];
    logic [31:0] ref_mem[16];
    bit          exp_err = 0;
    bit          spur_en = 0;
    bit          in_req  = 0;
    int          rc      = 0;
    exp_t        cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: per-instruction outcome from the architectural rules, program order memory.
    function automatic exp_t model(input ins_t i, input int lat);
        exp_t e;
        bit   memop;
        bit   abrt;
        memop      = i.v && (i.rd || i.wr);
        abrt       = memop && (lat >= TIMEOUT);
        e.has_req  = memop;
        e.lat      = lat;
        e.we       = i.wr && !i.rd;
        e.addr     = {i.alu[31:2], 2'b00};
        e.be       = 4'hF;
        e.wdata    = i.regb;
        e.retire   = i.v;
        e.rw       = i.rw && !abrt;
        e.wa       = i.wa;
        e.data     = i.alu;
        e.chk_data = !abrt;
        e.err      = abrt;
        e.stalls   = !memop ? 0 : (lat < TIMEOUT ? lat : TIMEOUT - 1);
        if (memop && i.rd && !abrt) e.data = ref_mem[i.alu[5:2]];
        if (memop && e.we && !abrt) ref_mem[i.alu[5:2]] = i.regb;
        return e;
    endfunction

    function automatic ins_t mk(input logic v, input logic rd, input logic wr, input logic rw,
                                input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] regb);
        ins_t i;
        i.v = v; i.rd = rd; i.wr = wr; i.rw = rw; i.wa = wa;
        i.alu = alu; i.regb = regb; i.size = 2'b10; i.sgn = 1'b0;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.v    = ($urandom_range(0, 9) != 0);
        i.rd   = 1'($urandom_range(0, 1));
        i.wr   = ($urandom_range(0, 2) == 0);
        i.rw   = 1'($urandom_range(0, 1));
        i.wa   = 5'($urandom);
        i.alu  = $urandom;
        i.regb = $urandom;
        i.size = 2'($urandom);
        i.sgn  = 1'($urandom);
`ifdef MEM_SUBWORD_EN
        i.alu[1:0] = 2'b00;
        i.size     = 2'b10;
`endif
        return i;
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 13) return int'($urandom_range(0, 3));
        if (r < 18) return int'($urandom_range(4, 15));
        return NEVER;
    endfunction

    // Memory responder: acks each request after its scheduled latency, checks the payload.
    always @(negedge clk) begin
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = $urandom;
        if (!dmem_bus.req) begin
            in_req = 0;
            if (spur_en && $urandom_range(0, 3) == 0) dmem_bus.ack = 1'b1;
        end else begin
            if (!in_req) begin
                in_req = 1;
                rc     = 0;
                if (req_q.size() == 0) begin
                    check("req_unexpected", {31'b0, dmem_bus.req}, 32'd0);
                    cur.lat = NEVER;
                end else begin
                    cur = req_q.pop_front();
                    check("req_we", {31'b0, dmem_bus.we}, {31'b0, cur.we});
                    check("req_addr", dmem_bus.addr, cur.addr);
                    check("req_be", {28'b0, dmem_bus.be}, {28'b0, cur.be});
                    if (cur.we) check("req_wdata", dmem_bus.wdata, cur.wdata);
                end
            end
            if (rc == cur.lat) begin
                dmem_bus.ack   = 1'b1;
                dmem_bus.rdata = phys[dmem_bus.addr[5:2]];
                if (dmem_bus.we) begin
                    for (int k = 0; k < 4; k++)
                        if (dmem_bus.be[k]) phys[dmem_bus.addr[5:2]][8*k +: 8] = dmem_bus.wdata[8*k +: 8];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (in_req) begin
            if (dmem_bus.ack || rc == TIMEOUT - 1) in_req = 0;
            else rc++;
        end
    end

    task automatic drive(input ins_t i);
        ex_valid = i.v; ex_MemRead = i.rd; ex_MemWrite = i.wr; ex_RegWrite = i.rw;
        ex_WriteAddr = i.wa; ex_ALUout = i.alu; ex_RegB = i.regb;
        ex_MemSize = i.size; ex_MemSigned = i.sgn;
    endtask

    task automatic check_wb();
        exp_t e;
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
            end else begin
                e = wb_q.pop_front();
                check("wb_regwrite", {31'b0, wb_RegWrite}, {31'b0, e.rw});
                check("wb_addr", {27'b0, wb_WriteAddr}, {27'b0, e.wa});
                if (e.chk_data) check("wb_data", ALU_out_MEM_WB_out, e.data);
                if (e.err) exp_err = 1;
            end
        end else begin
            check("bubble_regwrite", {31'b0, wb_RegWrite}, 32'd0);
        end
        check("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
    endtask

    // Present one instruction, let it enter EX/MEM, then follow it until it stops stalling.
    task automatic issue(input ins_t i, input exp_t e);
        int st;
        bit done;
        st   = 0;
        done = 0;
        drive(i);
        if (e.has_req) req_q.push_back(e);
        if (e.retire) wb_q.push_back(e);
        @(posedge clk); #1;
        check_wb();
        drive(rand_ins());
        for (int k = 0; k < 3 * TIMEOUT && !done; k++) begin
            @(negedge clk); #1;
            check("exmem_alu", ALUout_EX_MEM_out, i.alu);
            check("exmem_rw", {31'b0, RegWrite_EX_MEM}, {31'b0, i.v & i.rw});
            check("exmem_wa", {27'b0, WriteAddr_EX_MEM}, {27'b0, i.wa});
            if (!mem_stall) begin
                done = 1;
            end else begin
                st++;
                @(posedge clk); #1;
                check("stall_bubble", {31'b0, wb_valid}, 32'd0);
                check_wb();
            end
        end
        if (!done) check("stall_timeout", {31'b0, mem_stall}, 32'd0);
        check("stall_cycles", st, e.stalls);
    endtask

    initial begin
        ins_t i;
        exp_t e;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = '0;
        for (int k = 0; k < 16; k++) begin
            phys[k]    = $urandom;
            ref_mem[k] = phys[k];
        end

        #1 reset = 1'b0;
        #2;
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_req", {31'b0, dmem_bus.req}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_rw", {31'b0, wb_RegWrite}, 32'd0);
        check("rst_wb_data", ALU_out_MEM_WB_out, 32'd0);
        check("rst_exmem_alu", ALUout_EX_MEM_out, 32'd0);
        check("rst_mem_err", {31'b0, mem_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU op, same-cycle load/store, slow load, last-cycle ack, timeout.
        i = mk(1, 0, 0, 1, 5'd5, 32'h15, 32'h0);           issue(i, model(i, 0));
        phys[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
        i = mk(1, 1, 0, 1, 5'd6, 32'h40, 32'h0);           issue(i, model(i, 3));
        i = mk(1, 0, 1, 0, 5'd0, 32'h44, 32'h12345678);    issue(i, model(i, 0));
        i = mk(1, 1, 0, 1, 5'd7, 32'h44, 32'h0);           issue(i, model(i, 0));
        i = mk(1, 1, 0, 1, 5'd8, 32'h4C, 32'h0);           issue(i, model(i, TIMEOUT - 1));
        i = mk(1, 1, 0, 1, 5'd9, 32'h48, 32'h0);           issue(i, model(i, NEVER));
        i = mk(1, 0, 0, 1, 5'd10, 32'h77, 32'h0);          issue(i, model(i, 0));
        i = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);            issue(i, model(i, 0));

`ifdef MEM_SUBWORD_EN
        phys[0] = 32'h80FF0000; ref_mem[0] = 32'h80FF0000;
        i = mk(1, 1, 0, 1, 5'd11, 32'h43, 32'h0);
        i.size = 2'b00; i.sgn = 1'b1;
        e = model(i, 1);
        e.addr = 32'h43; e.be = 4'b1000; e.data = 32'hFFFFFF80;
        issue(i, e);
        i = mk(1, 1, 0, 1, 5'd12, 32'h41, 32'h0);
        i.size = 2'b01;
        e = model(i, 0);
        e.has_req = 0; e.rw = 0; e.chk_data = 0; e.err = 1; e.stalls = 0;
        issue(i, e);
        i = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);            issue(i, model(i, 0));
`endif

        // Asynchronous reset in the middle of a waiting access.
        i = mk(1, 1, 0, 1, 5'd13, 32'h50, 32'h0);
        e = model(i, NEVER);
        drive(i);
        req_q.push_back(e);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0));
        @(negedge clk); #1;
        check("pre_rst_stall", {31'b0, mem_stall}, 32'd1);
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        exp_err = 0;
        check("mid_rst_req", {31'b0, dmem_bus.req}, 32'd0);
        check("mid_rst_stall", {31'b0, mem_stall}, 32'd0);
        check("mid_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("mid_rst_mem_err", {31'b0, mem_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("no_retry_req", {31'b0, dmem_bus.req}, 32'd0);
        end

        // Random instruction stream with random memory latency and stray acks.
        spur_en = 1;
        for (int n = 0; n < 250; n++) begin
            i = rand_ins();
            issue(i, model(i, rand_lat()));
        end
        spur_en = 0;
        for (int n = 0; n < 2; n++) begin
            i = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
            issue(i, model(i, 0));
        end
        check("wb_drain", wb_q.size(), 32'd0);
        check("req_drain", req_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
